dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Sequencing controller for the `dds` phase-accumulator core. It owns the core's `freq_word`, `triangle_sym` and `int_dff_en` inputs. It accepts a configuration from the MCU register bridge through a valid/ready handshake and generates the sample-rate enable. It can hold a fixed tone or run a linear frequency sweep in single, repeating or up-down mode.

## Interface
- `FW_W`, 32: phase/frequency word width; must equal the `dds` core's `FW_W`.
- `DWELL_W`, 24: dwell counter width, in enable pulses.
- `DIV_W`, 16: sample-enable divider width.

- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  high only in IDLE; a transfer occurs when `cfg_valid` and `cfg_ready` are both high.
- `cfg_f_start`  in  FW_W  start frequency word (the fixed tone in mode 0).
- `cfg_f_stop`  in  FW_W  stop frequency word.
- `cfg_f_step`  in  FW_W  step increment.
- `cfg_dwell`  in  DWELL_W  enable pulses per frequency point; 0 is treated as 1.
- `cfg_sym`  in  FW_W  triangle symmetry point.
- `cfg_div`  in  DIV_W  enable period minus 1.
- `cfg_mode`  in  2  0 = fixed, 1 = single up sweep, 2 = repeating up sweep, 3 = up-down.
- `start`  in  1  one-cycle pulse; begins a sweep.
- `abort`  in  1  one-cycle pulse; stops a sweep.
- `int_dff_en`  out  1  sample enable to the core.
- `freq_word`  out  FW_W  to the core.
- `triangle_sym`  out  FW_W  to the core.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at sweep end.
- `step_mark`  out  1  one-cycle pulse in the same cycle `freq_word` takes a new sweep value.

## Operation
- All outputs and state are registered. Reset values:
  - `freq_word`, `triangle_sym`, `done`, `step_mark`, `int_dff_en`: 0.
  - `cfg_ready`: 1.
  - Active configuration: all 0.
  - Direction: up.
  - State: IDLE.
- **Enable divider**
  - Free-running counter `0..div_active`; `int_dff_en` is the registered result of `cnt == div_active`.
  - `div_active = 0` gives an enable every cycle.
  - On a config transfer, the counter clears to 0 and `div_active` takes `cfg_div`.
- **Config transfer (IDLE only)**
  - All `cfg_*` fields are latched into the active registers.
  - `freq_word` takes `cfg_f_start` and `triangle_sym` takes `cfg_sym`.
  - A transfer and a `start` in the same cycle: the transfer is taken; `start` uses the new config.
- **FSM states: IDLE, DWELL, STEP, DONE.**
- **IDLE**
  - `start` with mode 0 is ignored; the fixed tone is already applied.
  - `start` with `step == 0` or `f_start > f_stop` goes to DONE, with no sweep.
  - Otherwise `start` loads `freq_word` with `f_start`, sets direction up, clears the dwell counter and goes to DWELL.
- **DWELL**
  - The dwell counter increments on each `int_dff_en`.
  - On the enable that brings the count to `max(dwell,1)`, go to STEP.
- **STEP** lasts one cycle and computes the next point with FW_W+1-bit arithmetic.
  - Direction up: `sum = freq_word + step`.
    - If `sum ≤ f_stop`: `freq_word` takes `sum`, `step_mark` pulses, go to DWELL.
    - Otherwise the point is an end point. The carry-out case counts as an end point, so a wrapped value is never output.
  - Direction down: `diff = freq_word − step`.
    - If there is no borrow and `diff ≥ f_start`: `freq_word` takes `diff`, `step_mark` pulses, go to DWELL.
    - Otherwise the point is an end point.
  - End point, mode 1: go to DONE; `freq_word` holds.
  - End point, mode 2: `freq_word` takes `f_start`, `step_mark` pulses, go to DWELL.
  - End point, mode 3: flip direction; `freq_word` holds with no `step_mark`; go to DWELL. The extreme point is therefore dwelt twice.
  - The dwell counter clears on every exit from STEP.
- **DONE** lasts one cycle: `done` = 1, then go to IDLE.
- **`abort`**
  - Has the highest priority.
  - From DWELL, STEP or DONE it forces IDLE in the next cycle.
  - `freq_word` holds and `done` does not pulse.
  - In IDLE it is ignored.
- A `start` while busy is ignored.
- Reset asserted mid-sweep returns every output to its reset value immediately (asynchronous).

## Timing
- `start` in cycle T:
  - `busy` is high from T+1.
  - For a valid sweep, `freq_word` equals `f_start` at T+1.
- Each sweep point is held for `max(dwell,1)` enable periods plus 1 cycle (the STEP cycle).
- A new `freq_word` and its `step_mark` appear in the cycle after STEP.
- `done` is high for exactly one cycle. `busy` falls and `cfg_ready` rises in the cycle after `done`.
- After `abort` in cycle T: `busy` is 0 and `cfg_ready` is 1 at T+1.
- After a config transfer in cycle T: `freq_word` and `triangle_sym` are updated at T+1; the first new `int_dff_en` occurs at T+1+`div`.

## Test plan
1. Fixed tone: mode 0, `f_start = 0x0100_0000`, `div = 3` → `freq_word = 0x0100_0000` one cycle after the transfer; `int_dff_en` every 4th cycle; a following `start` leaves `busy = 0`.
2. Single sweep: start 100, stop 130, step 10, dwell 2, div 0 → `freq_word` runs 100, 110, 120, 130, each held 3 cycles; 3 `step_mark` pulses; 1 `done`; `freq_word` stays at 130 afterwards.
3. Up-down: start 0, stop 20, step 10, dwell 1 → `freq_word` sequence 0, 10, 20, 20, 10, 0, 0, 10…; no `step_mark` on the repeated points; `busy` stays high.
4. Repeat with carry: start `0xFFFF_FFE0`, stop `0xFFFF_FFFF`, step `0x10` → `freq_word` sequence E0, F0, E0, … (upper bits F); a wrapped value such as `0x0000_0000` never appears.
5. `abort` in DWELL → `busy` is 0 next cycle, no `done`, `freq_word` held, `cfg_ready` is 1. Separately, `rst_n` low mid-sweep → all outputs at their reset values without waiting for a clock edge.
6. Invalid config: `step = 0` (and separately `f_start = 200`, `f_stop = 100`) with `start` at T → `busy` and `done` both high only at T+1, `freq_word` unchanged, back in IDLE at T+2.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration bus from the MCU register bridge to dds_sweep_ctrl.
// A transfer occurs on a cycle where cfg_valid and cfg_ready are both high.
interface dds_sweep_ctrl_if #(
   parameter int FW_W    = 32,
   parameter int DWELL_W = 24,
   parameter int DIV_W   = 16
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [FW_W-1:0]    cfg_f_start;
   logic [FW_W-1:0]    cfg_f_stop;
   logic [FW_W-1:0]    cfg_f_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [FW_W-1:0]    cfg_sym;
   logic [DIV_W-1:0]   cfg_div;
   logic [1:0]         cfg_mode;

   modport master (
      output cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step,
             cfg_dwell, cfg_sym, cfg_div, cfg_mode,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step,
             cfg_dwell, cfg_sym, cfg_div, cfg_mode,
      output cfg_ready
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer for the dds core: owns freq_word, triangle_sym and the sample enable.
// Holds a fixed tone or runs single, repeating or up-down linear frequency sweeps.
module dds_sweep_ctrl #(
   parameter int FW_W    = 32,
   parameter int DWELL_W = 24,
   parameter int DIV_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   dds_sweep_ctrl_if.slave  cfg,
   input  logic             start,
   input  logic             abort,
   output logic             int_dff_en,
   output logic [FW_W-1:0]  freq_word,
   output logic [FW_W-1:0]  triangle_sym,
   output logic             busy,
   output logic             done,
   output logic             step_mark
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_STEP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               dir_up_q, dir_up_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               en_q, en_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [FW_W-1:0]    f_start_q, f_start_d;
   logic [FW_W-1:0]    f_stop_q, f_stop_d;
   logic [FW_W-1:0]    f_step_q, f_step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [1:0]         mode_q, mode_d;
   logic [FW_W-1:0]    freq_word_q, freq_word_d;
   logic [FW_W-1:0]    sym_q, sym_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               step_mark_q, step_mark_d;

   logic               xfer_s;
   logic               end_point_s;
   logic [DWELL_W-1:0] dwell_eff_s;
   logic [FW_W:0]      sum_s;
   logic [FW_W:0]      diff_s;

   // Next-state logic for the divider, active configuration and sweep FSM.
   always_comb begin
      xfer_s      = cfg.cfg_valid & ready_q & (state_q == S_IDLE);
      dwell_eff_s = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
      sum_s       = {1'b0, freq_word_q} + {1'b0, f_step_q};
      diff_s      = {1'b0, freq_word_q} - {1'b0, f_step_q};
      end_point_s = 1'b0;

      state_d     = state_q;
      dir_up_d    = dir_up_q;
      dwell_cnt_d = dwell_cnt_q;
      freq_word_d = freq_word_q;
      step_mark_d = 1'b0;

      if (xfer_s) begin
         cnt_d       = '0;
         div_d       = cfg.cfg_div;
         f_start_d   = cfg.cfg_f_start;
         f_stop_d    = cfg.cfg_f_stop;
         f_step_d    = cfg.cfg_f_step;
         dwell_d     = cfg.cfg_dwell;
         mode_d      = cfg.cfg_mode;
         sym_d       = cfg.cfg_sym;
         freq_word_d = cfg.cfg_f_start;
      end else begin
         cnt_d     = (cnt_q == div_q) ? '0 : (cnt_q + DIV_W'(1));
         div_d     = div_q;
         f_start_d = f_start_q;
         f_stop_d  = f_stop_q;
         f_step_d  = f_step_q;
         dwell_d   = dwell_q;
         mode_d    = mode_q;
         sym_d     = sym_q;
      end
      // Looking at the next count lets the first enable land exactly div cycles after a transfer.
      en_d = (cnt_d == div_d);

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (mode_d != 2'd0)) begin
                  if ((f_step_d == '0) || (f_start_d > f_stop_d)) begin
                     state_d = S_DONE;
                  end else begin
                     freq_word_d = f_start_d;
                     dir_up_d    = 1'b1;
                     dwell_cnt_d = '0;
                     state_d     = S_DWELL;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DWELL: begin
               if (en_q) begin
                  dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                  if ((dwell_cnt_q + DWELL_W'(1)) >= dwell_eff_s) begin
                     state_d = S_STEP;
                  end else begin
                     state_d = S_DWELL;
                  end
               end else begin
                  state_d = S_DWELL;
               end
            end
            S_STEP: begin
               dwell_cnt_d = '0;
               state_d     = S_DWELL;
               // The extra MSB catches carry/borrow so a wrapped word is never emitted.
               if (dir_up_q) begin
                  if (sum_s <= {1'b0, f_stop_q}) begin
                     freq_word_d = sum_s[FW_W-1:0];
                     step_mark_d = 1'b1;
                  end else begin
                     end_point_s = 1'b1;
                  end
               end else begin
                  if (!diff_s[FW_W] && (diff_s[FW_W-1:0] >= f_start_q)) begin
                     freq_word_d = diff_s[FW_W-1:0];
                     step_mark_d = 1'b1;
                  end else begin
                     end_point_s = 1'b1;
                  end
               end
               if (end_point_s) begin
                  case (mode_q)
                     2'd2: begin
                        freq_word_d = f_start_q;
                        step_mark_d = 1'b1;
                     end
                     2'd3: begin
                        dir_up_d = ~dir_up_q;
                     end
                     default: begin
                        state_d = S_DONE;
                     end
                  endcase
               end else begin
                  end_point_s = 1'b0;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         dir_up_q    <= 1'b1;
         cnt_q       <= '0;
         div_q       <= '0;
         en_q        <= 1'b0;
         dwell_cnt_q <= '0;
         f_start_q   <= '0;
         f_stop_q    <= '0;
         f_step_q    <= '0;
         dwell_q     <= '0;
         mode_q      <= 2'd0;
         freq_word_q <= '0;
         sym_q       <= '0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         step_mark_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_up_q    <= dir_up_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         en_q        <= en_d;
         dwell_cnt_q <= dwell_cnt_d;
         f_start_q   <= f_start_d;
         f_stop_q    <= f_stop_d;
         f_step_q    <= f_step_d;
         dwell_q     <= dwell_d;
         mode_q      <= mode_d;
         freq_word_q <= freq_word_d;
         sym_q       <= sym_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         step_mark_q <= step_mark_d;
      end
   end

   assign cfg.cfg_ready  = ready_q;
   assign int_dff_en     = en_q;
   assign freq_word      = freq_word_q;
   assign triangle_sym   = sym_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign step_mark      = step_mark_q;

endmodule
